spi_minion_arbiter: RTL and testbench
=====================================

# spi_minion_arbiter

Round-robin arbiter that shares the single upstream return path into the SPI push-pull adapter among `num_inputs` response-producing components. It is the reverse of the address-stripping router. Each accepted packet is tagged with its source index in the high-order address bits and buffered in a one-entry output register. Address encoding matches the router, so a packet looped through the arbiter and then the router lands at the same index.

## Interface
- `nbits`, 4, data bits per packet.
- `num_inputs`, 2, number of requesters.
- `addr_nbits`, `max(1, $clog2(num_inputs))`, width of the source-address field.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`.
- `recv_msg`  in  `nbits` x `num_inputs` (unpacked array `[0:num_inputs-1]`)  per-requester data.
- `recv_val`  in  1 x `num_inputs`  per-requester valid.
- `recv_rdy`  out  1 x `num_inputs`  per-requester ready; at most one bit high in any cycle.
- `send_msg`  out  `addr_nbits+nbits`  packet sent toward the adapter, `{source_index, data}`.
- `send_val`  out  1  output register holds a packet.
- `send_rdy`  in  1  adapter accepts the packet.

## Operation
- State:
  - `full` (1 bit): output register occupancy. State EMPTY when `full`=0, FULL when `full`=1.
  - `data_reg` (`addr_nbits+nbits`): driven directly on `send_msg`.
  - `ptr` (`addr_nbits`): round-robin priority pointer.
- `send_val` = `full`. `send_msg` = `data_reg`.
- `can_accept` = `!full | send_rdy`. A packet may be drained and a new one loaded in the same cycle.
- Grant (combinational):
  - Scan indices `ptr, ptr+1, …, num_inputs-1, 0, …, ptr-1`.
  - `grant` is the first index with `recv_val` high. `any_val` is high when any requester is valid.
- `recv_rdy[i]` = `can_accept & any_val & (i == grant)`. All other bits are 0.
- Transfer from requester i occurs when `recv_val[i] & recv_rdy[i]`. On that edge:
  - `data_reg` <= `{grant[addr_nbits-1:0], recv_msg[grant]}`.
  - `full` <= 1.
  - `ptr` <= `grant+1`, wrapping to 0 when `grant == num_inputs-1`.
- On a drain (`full & send_rdy`) with no transfer: `full` <= 0. `data_reg` is unchanged.
- When no transfer occurs, `ptr` holds.
- State transitions:
  - EMPTY→FULL on transfer.
  - FULL→FULL on drain+transfer, or on stall (`send_rdy`=0).
  - FULL→EMPTY on drain without transfer.
- Address values ≥ `num_inputs` are never produced. The pointer never holds a value ≥ `num_inputs`.
- With `num_inputs`=1, the address field is the single bit 0.
- Requesters follow val/rdy: once `recv_val` is asserted, `recv_msg` stays stable until accepted. The arbiter does not check this.
- The arbiter never drops or duplicates a packet except on reset.

## Timing
- Reset values: `send_val`=0, `send_msg`=0, every `recv_rdy`=0 (forced by `any_val`/reset state while `reset` is high), `ptr`=0, `full`=0.
- Latency: a packet accepted at edge k appears on `send_msg` with `send_val`=1 in the cycle after edge k (1 cycle).
- Throughput: with `send_rdy` held high, one packet per cycle.
- `recv_rdy` depends combinationally on `recv_val`, `send_rdy` and state. There is no combinational path from `recv_msg` to any output.
- While FULL and `send_rdy`=0, `send_msg` is held constant and all `recv_rdy` are 0.
- Reset asserted mid-operation:
  - A buffered packet is discarded.
  - `send_val` falls immediately, without waiting for a clock edge.
  - After release, arbitration restarts from index 0.

## Test plan
All scenarios use `nbits`=4, `num_inputs`=3, `addr_nbits`=2.
- Reset: assert `reset` with all inputs high, then release with all `recv_val`=0 → `send_val`=0, `send_msg`=0x00, `recv_rdy`=000; pulsing reset asynchronously between edges clears a FULL register at once.
- Single transfer: `recv_val[1]`=1, `recv_msg[1]`=0xA, `send_rdy`=1 → `recv_rdy[1]`=1 that cycle; next cycle `send_val`=1, `send_msg`=0x1A (`01_1010`).
- Fairness: all three valid continuously with data 0x3/0x5/0x7, `send_rdy`=1 → `send_msg` sequence 0x03, 0x15, 0x27, 0x03, …, one packet per cycle, no index granted twice in a row.
- Backpressure: register FULL with 0x1A, `send_rdy`=0 for 4 cycles while `recv_val[2]`=1 → `send_msg` stays 0x1A and `recv_rdy`=000; raise `send_rdy` → same cycle `recv_rdy[2]`=1, next cycle `send_msg`=0x2x, with no bubble.
- Wrap and skip: `ptr`=2 (after granting 1), only `recv_val[0]` and `recv_val[1]` high → grant 0 first, then 1; `ptr` ends at 2.
- Drain to empty: FULL, `send_rdy`=1, no `recv_val` → next cycle `send_val`=0, `send_msg` unchanged, `ptr` unchanged.

Source files
------------

// File: rtl/spi_minion_arbiter_if.sv
// spi_minion_arbiter_if: requester-side and adapter-side val/rdy bundle for the arbiter
interface spi_minion_arbiter_if #(
  parameter int nbits = 4,
  parameter int num_inputs = 2,
  parameter int addr_nbits = (num_inputs > 1) ? $clog2(num_inputs) : 1
);
  logic [nbits-1:0] recv_msg [0:num_inputs-1];
  logic [num_inputs-1:0] recv_val;
  logic [num_inputs-1:0] recv_rdy;
  logic [addr_nbits+nbits-1:0] send_msg;
  logic send_val;
  logic send_rdy;
  modport master (output recv_msg, recv_val, send_rdy, input recv_rdy, send_msg, send_val);
  modport slave (input recv_msg, recv_val, send_rdy, output recv_rdy, send_msg, send_val);
endinterface

// File: rtl/spi_minion_arbiter.sv
// spi_minion_arbiter: round-robin merge of requesters into one source-tagged, one-entry output register
module spi_minion_arbiter #(
  parameter int nbits = 4,
  parameter int num_inputs = 2,
  parameter int addr_nbits = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input logic clk,
  input logic reset,
  spi_minion_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [addr_nbits+nbits-1:0] data_q, data_d;
  logic [addr_nbits-1:0] ptr_q, ptr_d, grant;
  logic any_val, can_accept, xfer;
  function automatic logic [addr_nbits-1:0] wrap(input int v);
    return addr_nbits'(v >= num_inputs ? v - num_inputs : v);
  endfunction
  // scan from farthest to nearest so the index closest to ptr wins
  always_comb begin
    grant = ptr_q;
    for (int k = num_inputs - 1; k >= 0; k--)
      if (bus.recv_val[wrap(int'(ptr_q) + k)]) grant = wrap(int'(ptr_q) + k);
    any_val = |bus.recv_val;
    can_accept = state_q == EMPTY || bus.send_rdy;
    xfer = !reset && can_accept && any_val;
    for (int i = 0; i < num_inputs; i++) bus.recv_rdy[i] = xfer && grant == addr_nbits'(i);
    state_d = (xfer || (state_q == FULL && !bus.send_rdy)) ? FULL : EMPTY;
    data_d = xfer ? {grant, bus.recv_msg[grant]} : data_q;
    ptr_d = !xfer ? ptr_q : (grant == addr_nbits'(num_inputs - 1)) ? '0 : grant + addr_nbits'(1);
    bus.send_val = state_q == FULL;
    bus.send_msg = data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_spi_minion_arbiter.sv
// tb_spi_minion_arbiter: directed stimulus with a queue-based scoreboard on the send side
module tb_spi_minion_arbiter;
  logic clk, reset;
  int passes = 0;
  int total = 0;
  logic [5:0] exp_q [$];
  logic [5:0] fm [0:5] = '{6'h27, 6'h03, 6'h15, 6'h27, 6'h03, 6'h15};
  logic [2:0] fr [0:5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  spi_minion_arbiter_if #(.nbits(4), .num_inputs(3), .addr_nbits(2)) bus ();
  spi_minion_arbiter #(.nbits(4), .num_inputs(3), .addr_nbits(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic neg;
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (!reset && bus.send_val && bus.send_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL mon_extra: got %0h expected no packet", bus.send_msg);
      end else chk("mon_msg", 32'(bus.send_msg), 32'(exp_q.pop_front()));
    end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    reset = 1;
    bus.recv_val = '1;
    for (int i = 0; i < 3; i++) bus.recv_msg[i] = 4'hF;
    bus.send_rdy = 1;
    repeat (2) @(posedge clk);
    neg;
    chk("rst_val", 32'(bus.send_val), 0);
    chk("rst_rdy", 32'(bus.recv_rdy), 0);
    bus.recv_val = '0;
    reset = 0;
    cyc;
    neg;
    chk("post_rst_val", 32'(bus.send_val), 0);
    chk("post_rst_msg", 32'(bus.send_msg), 0);
    chk("post_rst_rdy", 32'(bus.recv_rdy), 0);
    cyc;
    bus.recv_val = 3'b010;
    bus.recv_msg[1] = 4'hA;
    exp_q.push_back(6'h1A);
    neg;
    chk("single_rdy", 32'(bus.recv_rdy), 3'b010);
    cyc;
    bus.recv_val = '0;
    neg;
    chk("single_val", 32'(bus.send_val), 1);
    chk("single_msg", 32'(bus.send_msg), 6'h1A);
    cyc;
    neg;
    chk("drain_val", 32'(bus.send_val), 0);
    chk("drain_msg", 32'(bus.send_msg), 6'h1A);
    cyc;
    bus.recv_msg[0] = 4'h3;
    bus.recv_msg[1] = 4'h5;
    bus.recv_msg[2] = 4'h7;
    bus.recv_val = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(fm[i]);
      neg;
      chk("fair_rdy", 32'(bus.recv_rdy), 32'(fr[i]));
      cyc;
    end
    bus.recv_val = 3'b011;
    exp_q.push_back(6'h03);
    neg;
    chk("wrap_rdy0", 32'(bus.recv_rdy), 3'b001);
    cyc;
    exp_q.push_back(6'h15);
    neg;
    chk("wrap_rdy1", 32'(bus.recv_rdy), 3'b010);
    cyc;
    bus.recv_val = 3'b111;
    exp_q.push_back(6'h27);
    neg;
    chk("wrap_ptr2", 32'(bus.recv_rdy), 3'b100);
    cyc;
    bus.recv_val = 3'b010;
    bus.recv_msg[1] = 4'hA;
    exp_q.push_back(6'h1A);
    neg;
    chk("bp_load_rdy", 32'(bus.recv_rdy), 3'b010);
    cyc;
    bus.recv_val = 3'b100;
    bus.send_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      neg;
      chk("bp_rdy", 32'(bus.recv_rdy), 0);
      chk("bp_msg", 32'(bus.send_msg), 6'h1A);
      cyc;
    end
    bus.send_rdy = 1;
    exp_q.push_back(6'h27);
    neg;
    chk("bp_release_rdy", 32'(bus.recv_rdy), 3'b100);
    cyc;
    bus.recv_val = '0;
    neg;
    chk("bp_nobubble", 32'(bus.send_msg), 6'h27);
    cyc;
    neg;
    chk("drain2_val", 32'(bus.send_val), 0);
    chk("drain2_msg", 32'(bus.send_msg), 6'h27);
    cyc;
    bus.recv_val = 3'b111;
    exp_q.push_back(6'h03);
    neg;
    chk("drain2_ptr", 32'(bus.recv_rdy), 3'b001);
    cyc;
    bus.recv_val = '0;
    neg;
    cyc;
    bus.recv_val = 3'b010;
    bus.send_rdy = 0;
    @(posedge clk);
    #2;
    chk("ar_full", 32'(bus.send_val), 1);
    reset = 1;
    #1;
    chk("ar_val", 32'(bus.send_val), 0);
    chk("ar_msg", 32'(bus.send_msg), 0);
    reset = 0;
    #1;
    bus.recv_val = 3'b111;
    bus.send_rdy = 1;
    exp_q.push_back(6'h03);
    neg;
    chk("ar_restart", 32'(bus.recv_rdy), 3'b001);
    cyc;
    bus.recv_val = '0;
    neg;
    cyc;
    neg;
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
